stopwatch_time_counter: RTL and testbench
=========================================

// Module: stopwatch_time_counter
// PURPOSE
//   Consumes the divided clocks from the stopwatch clock divider and keeps MM:SS time
//   as four BCD digits for the 7-segment display driver. Supports run/pause and an
//   adjust mode in which the selected field is stepped at 2 Hz.
//   The divided clocks are treated as data levels. They are edge-detected into
//   single-cycle enables. All state is clocked on clk only.
// PARAMETERS
//   SEC_MAX  59  last seconds value before wrap to 0 (decimal, 1..99)
//   MIN_MAX  59  last minutes value before wrap to 0 (decimal, 1..99)
// PORTS
//   clk        in   1  master clock, 100 MHz
//   reset      in   1  asynchronous, active-low reset (0 = in reset)
//   clk_1hz    in   1  1 Hz square wave from divider, synchronous to clk
//   clk_2hz    in   1  2 Hz square wave from divider, synchronous to clk
//   pause_p    in   1  debounced single-cycle pulse; toggles run/pause
//   adj        in   1  1 = adjust mode, 0 = normal counting
//   sel        in   1  adjust field select: 0 = minutes, 1 = seconds
//   min_tens   out  4  BCD minutes tens digit
//   min_ones   out  4  BCD minutes ones digit
//   sec_tens   out  4  BCD seconds tens digit
//   sec_ones   out  4  BCD seconds ones digit
//   paused     out  1  1 = counting halted
//   wrap_p     out  1  1-cycle pulse when time wraps from MIN_MAX:SEC_MAX to 00:00
// BEHAVIOUR
//   Reset (reset=0, async): all digits 0, paused=0, wrap_p=0.
//     The edge-detect flops for clk_1hz and clk_2hz reset to 1. This prevents a
//     spurious rise on the first cycle after reset.
//   Edge detect: rise_1 = clk_1hz & ~q1; rise_2 = clk_2hz & ~q2. q1 and q2 are
//     registered copies of the inputs.
//     A rise is asserted in the first clk cycle in which the input is sampled high.
//     Digit registers update on that same clk edge, so latency is 0 cycles from the
//     detected rise and outputs are valid the following cycle.
//   Normal mode (adj=0, paused=0), on rise_1:
//     sec += 1. At SEC_MAX, sec -> 0 and min += 1.
//     At MIN_MAX:SEC_MAX, both fields -> 0 and wrap_p=1 for exactly one cycle.
//   Normal mode, paused=1: rise_1 is ignored and the digits hold.
//   Adjust mode (adj=1): rise_1 is ignored. On rise_2, the field chosen by sel
//     increments by 1 and wraps at its MAX back to 0.
//     There is no carry into the other field and wrap_p stays 0.
//     Adjust stepping happens regardless of paused.
//   pause_p toggles paused on the edge where it is sampled high, in any mode.
//     If pause_p and rise_1 occur in the same cycle, the tick is evaluated with the
//     pre-toggle paused value. Example: running + pause_p + rise_1 -> the tick
//     counts, then paused=1.
//   adj and sel are sampled each cycle.
//     Changing adj mid-second does not reset the second.
//     Leaving adjust mode resumes from the adjusted value on the next rise_1.
//   Digit arithmetic:
//     ones wraps 9 -> 0 and increments tens.
//     Field value = tens*10 + ones, compared against the MAX parameter.
//     Digits never hold a value above 9.
//   Reset mid-count: all digits clear immediately (async), with no wrap_p pulse.
// TESTING
//   1. Reset, drive 61 clk_1hz rises -> 01:01, wrap_p never high.
//   2. Preload 59:58, 2 rises -> 59:59 then 00:00, wrap_p high for exactly 1 cycle.
//   3. At 00:05, pulse pause_p, drive 3 rises -> holds 00:05.
//      Pulse pause_p again, 1 rise -> 00:06.
//   4. adj=1, sel=1 at 00:58, drive 3 clk_2hz rises -> 00:01 with minutes unchanged.
//      clk_1hz rises in the same window have no effect.
//   5. Running, with pause_p coincident with rise_1 at 00:09 -> 00:10 and paused=1.
//   6. Assert reset=0 mid-count at 12:34 -> all digits 0 and paused=0
//      asynchronously. No count on the first cycle after release while clk_1hz=1.

Source files
------------

// File: rtl/stopwatch_time_counter.sv
// MM:SS stopwatch counter in BCD, driven by edge-detected 1 Hz / 2 Hz divider levels.
// Supports run/pause and a per-field adjust mode stepped on the 2 Hz rise.
module stopwatch_time_counter #(
    parameter int unsigned SEC_MAX = 59,
    parameter int unsigned MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       pause_p,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused,
    output logic       wrap_p
);

    logic       q1_q, q2_q;
    logic       rise_1, rise_2;
    logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    logic [3:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
    logic       paused_q, paused_d;
    logic       wrap_q, wrap_d;
    logic       sec_at_max, min_at_max;

    function automatic logic at_max(input logic [3:0] tens, input logic [3:0] ones,
                                    input int unsigned max_val);
        logic [6:0] value;
        value = {3'b000, tens} * 7'd10 + {3'b000, ones};
        return value == max_val[6:0];
    endfunction

    // Returns {tens, ones} stepped by one, or 00 when the field is at its limit.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones,
                                           input logic wrap);
        if (wrap) begin
            return 8'h00;
        end else if (ones == 4'd9) begin
            return {tens + 4'd1, 4'd0};
        end else begin
            return {tens, ones + 4'd1};
        end
    endfunction

    always_comb begin
        rise_1     = clk_1hz & ~q1_q;
        rise_2     = clk_2hz & ~q2_q;
        sec_at_max = at_max(sec_tens_q, sec_ones_q, SEC_MAX);
        min_at_max = at_max(min_tens_q, min_ones_q, MIN_MAX);

        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        wrap_d     = 1'b0;
        // Tick logic below sees the pre-toggle paused_q.
        paused_d   = paused_q ^ pause_p;

        if (adj) begin
            if (rise_2) begin
                if (sel) begin
                    {sec_tens_d, sec_ones_d} = bcd_inc(sec_tens_q, sec_ones_q, sec_at_max);
                end else begin
                    {min_tens_d, min_ones_d} = bcd_inc(min_tens_q, min_ones_q, min_at_max);
                end
            end
        end else if (rise_1 && !paused_q) begin
            {sec_tens_d, sec_ones_d} = bcd_inc(sec_tens_q, sec_ones_q, sec_at_max);
            if (sec_at_max) begin
                {min_tens_d, min_ones_d} = bcd_inc(min_tens_q, min_ones_q, min_at_max);
                wrap_d = min_at_max;
            end
        end
    end

    // Edge-detect flops reset high so a level already high at release is not a rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q1_q       <= 1'b1;
            q2_q       <= 1'b1;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            paused_q   <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            q1_q       <= clk_1hz;
            q2_q       <= clk_2hz;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            paused_q   <= paused_d;
            wrap_q     <= wrap_d;
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign paused   = paused_q;
    assign wrap_p   = wrap_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: directed scenarios plus a randomized run, all checked
// against an integer minutes/seconds reference model.
module tb_stopwatch_time_counter;

    localparam int SecMax = 59;
    localparam int MinMax = 59;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_1hz = 1'b0;
    logic       clk_2hz = 1'b0;
    logic       pause_p = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       paused, wrap_p;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: plain integers for the time, previous input levels for rise detection.
    int m_sec, m_min;
    bit m_paused, m_wrap, m_prev1, m_prev2;

    stopwatch_time_counter #(
        .SEC_MAX(SecMax),
        .MIN_MAX(MinMax)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_1hz  (clk_1hz),
        .clk_2hz  (clk_2hz),
        .pause_p  (pause_p),
        .adj      (adj),
        .sel      (sel),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .paused   (paused),
        .wrap_p   (wrap_p)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_digits();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    task automatic model_reset();
        m_sec = 0; m_min = 0; m_paused = 0; m_wrap = 0; m_prev1 = 1; m_prev2 = 1;
    endtask

    // One clk cycle: drive at negedge, advance the model at posedge, return 1 ns later.
    task automatic tick(input bit c1, input bit c2, input bit pp, input bit a, input bit s);
        bit r1, r2;
        @(negedge clk);
        clk_1hz = c1; clk_2hz = c2; pause_p = pp; adj = a; sel = s;
        @(posedge clk);
        r1 = c1 && !m_prev1;
        r2 = c2 && !m_prev2;
        m_wrap = 0;
        if (a) begin
            if (r2) begin
                if (s) m_sec = (m_sec + 1) % (SecMax + 1);
                else   m_min = (m_min + 1) % (MinMax + 1);
            end
        end else if (r1 && !m_paused) begin
            m_sec++;
            if (m_sec > SecMax) begin
                m_sec = 0;
                m_min++;
                if (m_min > MinMax) begin
                    m_min = 0;
                    m_wrap = 1;
                end
            end
        end
        if (pp) m_paused = !m_paused;
        m_prev1 = c1;
        m_prev2 = c2;
        #1;
        pause_p = 1'b0;
    endtask

    task automatic run_rises(input int n);
        for (int i = 0; i < n; i++) begin
            tick(0, 0, 0, 0, 0);
            tick(1, 0, 0, 0, 0);
        end
    endtask

    task automatic adjust_to(input int target, input bit s);
        for (int i = 0; i < 100 && (s ? m_sec : m_min) != target; i++) begin
            tick(0, 0, 0, 1, s);
            tick(0, 1, 0, 1, s);
        end
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        vectors++;
        if ({min_tens, min_ones, sec_tens, sec_ones, paused, wrap_p} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h/%b/%b, want 0000/0/0",
                     {min_tens, min_ones, sec_tens, sec_ones}, paused, wrap_p);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_count_61();
        bit seen_wrap = 0;
        for (int i = 0; i < 61; i++) begin
            tick(0, 0, 0, 0, 0);
            if (wrap_p) seen_wrap = 1;
            tick(1, 0, 0, 0, 0);
            if (wrap_p) seen_wrap = 1;
        end
        vectors++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0101) begin
            miscompares++;
            $display("FAIL count_61: got %h, want 0101", {min_tens, min_ones, sec_tens, sec_ones});
        end
        vectors++;
        if (seen_wrap) begin
            miscompares++;
            $display("FAIL count_61_wrap: got wrap_p high, want never high");
        end
    endtask

    task automatic test_wrap();
        adjust_to(MinMax, 0);
        adjust_to(SecMax - 1, 1);
        vectors++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h5958) begin
            miscompares++;
            $display("FAIL adjust_preload: got %h, want 5958",
                     {min_tens, min_ones, sec_tens, sec_ones});
        end
        run_rises(1);
        vectors++;
        if ({min_tens, min_ones, sec_tens, sec_ones, wrap_p} !== {16'h5959, 1'b0}) begin
            miscompares++;
            $display("FAIL to_5959: got %h wrap=%b, want 5959 wrap=0",
                     {min_tens, min_ones, sec_tens, sec_ones}, wrap_p);
        end
        run_rises(1);
        vectors++;
        if ({min_tens, min_ones, sec_tens, sec_ones, wrap_p} !== {16'h0000, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_edge: got %h wrap=%b, want 0000 wrap=1",
                     {min_tens, min_ones, sec_tens, sec_ones}, wrap_p);
        end
        tick(1, 0, 0, 0, 0);
        vectors++;
        if (wrap_p !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_one_cycle: got wrap=%b, want 0", wrap_p);
        end
    endtask

    task automatic test_pause();
        run_rises(5);
        tick(0, 0, 1, 0, 0);
        vectors++;
        if (paused !== 1'b1) begin
            miscompares++;
            $display("FAIL pause_set: got paused=%b, want 1", paused);
        end
        run_rises(3);
        vectors++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0005) begin
            miscompares++;
            $display("FAIL pause_hold: got %h, want 0005", {min_tens, min_ones, sec_tens, sec_ones});
        end
        tick(0, 0, 1, 0, 0);
        run_rises(1);
        vectors++;
        if ({min_tens, min_ones, sec_tens, sec_ones, paused} !== {16'h0006, 1'b0}) begin
            miscompares++;
            $display("FAIL pause_resume: got %h paused=%b, want 0006 paused=0",
                     {min_tens, min_ones, sec_tens, sec_ones}, paused);
        end
    endtask

    task automatic test_adjust_seconds();
        run_rises(52);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1, 1);
            tick(1, 1, 0, 1, 1);
        end
        vectors++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0001) begin
            miscompares++;
            $display("FAIL adjust_sec_wrap: got %h, want 0001",
                     {min_tens, min_ones, sec_tens, sec_ones});
        end
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_pause_coincident();
        run_rises(8);
        tick(0, 0, 0, 0, 0);
        tick(1, 0, 1, 0, 0);
        vectors++;
        if ({min_tens, min_ones, sec_tens, sec_ones, paused} !== {16'h0010, 1'b1}) begin
            miscompares++;
            $display("FAIL pause_coincident: got %h paused=%b, want 0010 paused=1",
                     {min_tens, min_ones, sec_tens, sec_ones}, paused);
        end
    endtask

    task automatic test_async_reset();
        tick(0, 0, 1, 0, 0);
        adjust_to(12, 0);
        adjust_to(34, 1);
        vectors++;
        if ({min_tens, min_ones, sec_tens, sec_ones, paused} !== {16'h1234, 1'b0}) begin
            miscompares++;
            $display("FAIL preload_1234: got %h paused=%b, want 1234 paused=0",
                     {min_tens, min_ones, sec_tens, sec_ones}, paused);
        end
        tick(0, 0, 1, 0, 0);
        tick(1, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({min_tens, min_ones, sec_tens, sec_ones, paused, wrap_p} !== 18'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h paused=%b wrap=%b, want 0000 paused=0 wrap=0",
                     {min_tens, min_ones, sec_tens, sec_ones}, paused, wrap_p);
        end
        @(negedge clk);
        reset = 1'b1;
        tick(1, 0, 0, 0, 0);
        vectors++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000) begin
            miscompares++;
            $display("FAIL no_rise_after_reset: got %h, want 0000",
                     {min_tens, min_ones, sec_tens, sec_ones});
        end
    endtask

    task automatic test_random();
        bit c1 = 1, c2 = 0, a = 0, s = 0, pp;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) c1 = !c1;
            if ($urandom_range(0, 2) == 0) c2 = !c2;
            if ($urandom_range(0, 99) == 0) a = !a;
            if ($urandom_range(0, 19) == 0) s = !s;
            pp = ($urandom_range(0, 39) == 0);
            tick(c1, c2, pp, a, s);
            vectors++;
            if ({min_tens, min_ones, sec_tens, sec_ones, paused, wrap_p} !==
                {model_digits(), m_paused, m_wrap}) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h p=%b w=%b, want %h p=%b w=%b", i,
                         {min_tens, min_ones, sec_tens, sec_ones}, paused, wrap_p,
                         model_digits(), m_paused, m_wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_61();
        test_wrap();
        test_pause();
        test_adjust_seconds();
        test_pause_coincident();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
